fifo_rd_stream_adapter: RTL and testbench

- Read-side consumer for the async FIFO read-pointer block, in the r_clk domain.
- Drives r_en from r_empty / r_almost_empty and captures r_data after a fixed memory read latency.
- Re-presents the words as a valid/ready stream through a small credit-protected output buffer.
- Supports flush and enable control, and keeps a popped-word counter.

---
 rtl/fifo_rd_stream_adapter.sv | 132 +++++++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side consumer of the async FIFO: issues r_en, captures words after a fixed read latency
// and re-presents them as a valid/ready stream through a credit-protected buffer.
module fifo_rd_stream_adapter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned BUF_DEPTH  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  r_empty,
    input  logic                  r_almost_empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  flush_busy,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned LatW = $clog2(RD_LATENCY + 1);
    localparam int unsigned SumW = $clog2(BUF_DEPTH + RD_LATENCY + 3);

    typedef enum logic [1:0] {StIdle, StFetch, StEmptyWait, StFlush} state_e;

    state_e                  state_q, state_d;
    logic                    wait_q, wait_d;
    logic                    r_en_q, r_en_d;
    logic [RD_LATENCY-1:0]   sr_q, sr_d;
    logic [DATA_WIDTH-1:0]   mem_q [BUF_DEPTH];
    logic [PtrW-1:0]         wptr_q, rptr_q;
    logic [OccW-1:0]         occ_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    logic                    almost_hit;
    logic                    push;
    logic                    pop;
    logic [LatW-1:0]         inflight;
    logic [SumW-1:0]         used;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + LatW'(sr_q[i]);
        end
    end

    assign almost_hit = r_en_q & r_almost_empty;
    assign pop        = out_valid & out_ready;
    assign push       = sr_q[RD_LATENCY-1] & (state_q != StFlush) & ~flush;
    assign sr_d       = (sr_q << 1) | RD_LATENCY'(r_en_q);

    always_comb begin
        state_d = state_q;
        wait_d  = 1'b0;
        if (flush) begin
            state_d = StFlush;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable) state_d = StFetch;
                end
                StFetch: begin
                    // A last-word hit wins over enable falling so r_empty can catch up
                    if (almost_hit) state_d = StEmptyWait;
                    else if (!enable) state_d = StIdle;
                end
                StEmptyWait: begin
                    if (wait_q) state_d = enable ? StFetch : StIdle;
                    else wait_d = 1'b1;
                end
                StFlush: begin
                    if (inflight == '0) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Credit: buffered + landing + the read on r_en now, minus the word leaving this cycle
    always_comb begin
        used   = SumW'(occ_q) + SumW'(inflight) + SumW'(r_en_q) - SumW'(pop);
        r_en_d = (state_q == StFetch) && (state_d == StFetch) && !r_empty &&
                 (used < SumW'(BUF_DEPTH));
    end

    always_ff @(posedge r_clk) begin
        if (!rrst_n) begin
            state_q <= StIdle;
            wait_q  <= 1'b0;
            r_en_q  <= 1'b0;
            sr_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            r_en_q  <= r_en_d;
            sr_q    <= sr_d;
            if (pop) cnt_q <= cnt_q + 1'b1;
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
                occ_q  <= '0;
            end else begin
                if (push) begin
                    mem_q[wptr_q] <= r_data;
                    wptr_q        <= wptr_q + 1'b1;
                end
                if (pop) rptr_q <= rptr_q + 1'b1;
                occ_q <= occ_q + OccW'(push) - OccW'(pop);
            end
        end
    end

    assign r_en       = r_en_q;
    assign out_valid  = (occ_q != '0);
    assign out_data   = mem_q[rptr_q];
    assign flush_busy = (state_q == StFlush) && (inflight != '0);
    assign rd_count   = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: FIFO read-side model, expected-word queue and a stream
// monitor that pops and compares on every handshake.
module tb_fifo_rd_stream_adapter;

    logic       r_clk = 1'b0;
    logic       rrst_n = 1'b0;
    logic       enable = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       r_empty;
    logic       r_almost_empty;
    logic [7:0] r_data;
    logic       r_en;
    logic       out_valid;
    logic [7:0] out_data;
    logic       flush_busy;
    logic [3:0] rd_count;

    int total = 0;
    int bad = 0;
    int rden_cnt = 0;
    int hs_cnt = 0;
    logic [7:0] sb[$];

    // FIFO model: registered empty flag (one cycle late), two-cycle read data latency
    logic [7:0] fmem [0:127];
    int         head = 0;
    int         tail = 0;
    logic [7:0] s0 = 8'h00;
    logic [7:0] s1 = 8'h00;
    logic       r_empty_q = 1'b1;

    always #5 r_clk = ~r_clk;

    always @(posedge r_clk) begin
        r_empty_q <= (tail == head);
        s1 <= s0;
        if (r_en && (tail != head)) begin
            s0   <= fmem[head];
            head <= head + 1;
        end
    end

    assign r_empty        = r_empty_q;
    assign r_almost_empty = ((tail - head) == 1);
    assign r_data         = s1;

    fifo_rd_stream_adapter #(
        .DATA_WIDTH(8),
        .RD_LATENCY(2),
        .BUF_DEPTH (4),
        .CNT_WIDTH (4)
    ) dut (
        .r_clk         (r_clk),
        .rrst_n        (rrst_n),
        .enable        (enable),
        .flush         (flush),
        .r_empty       (r_empty),
        .r_almost_empty(r_almost_empty),
        .r_data        (r_data),
        .r_en          (r_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .flush_busy    (flush_busy),
        .rd_count      (rd_count)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic load(input logic [7:0] first, input int n, input bit exp_push);
        logic [7:0] w;
        for (int i = 0; i < n; i++) begin
            w = first + 8'(i);
            fmem[tail] = w;
            if (exp_push) sb.push_back(w);
            tail++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_r_en"}, int'(r_en), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_flush_busy"}, int'(flush_busy), 0);
        check({tag, "_rd_count"}, int'(rd_count), 0);
    endtask

    task automatic monitor();
        logic [7:0] exp_w;
        logic       prev_hold;
        logic [7:0] prev_d;
        prev_hold = 1'b0;
        prev_d    = 8'h00;
        forever begin
            @(negedge r_clk);
            if (rrst_n) begin
                if (r_en) begin
                    rden_cnt++;
                    check("fifo_underflow", int'(tail == head), 0);
                end
                if (dut.push && !dut.pop) check("buf_overflow", int'(dut.occ_q == 3'd4), 0);
                if (prev_hold && out_valid) check("hold_stable", int'(out_data), int'(prev_d));
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_word: got %0h required none", out_data);
                    end else begin
                        exp_w = sb.pop_front();
                        check("stream_data", int'(out_data), int'(exp_w));
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_d    = out_data;
            end else begin
                prev_hold = 1'b0;
            end
        end
    endtask

    initial begin
        int base;
        int n;
        int busy;
        int rem;
        fork
            monitor();
        join_none

        repeat (3) tick();
        check_reset_vals("rst");
        rrst_n = 1'b1;

        // Six-word burst with the sink always ready
        base = rden_cnt;
        load(8'h11, 6, 1'b1);
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (40) tick();
        check("t1_reads", rden_cnt - base, 6);
        check("t1_rd_count", int'(rd_count), 6);
        check("t1_sb_empty", sb.size(), 0);

        // Back-pressure: credit limits reads to buffer depth
        out_ready = 1'b0;
        base = rden_cnt;
        load(8'h21, 10, 1'b1);
        repeat (20) tick();
        check("t2_reads_stalled", rden_cnt - base, 4);
        check("t2_valid", int'(out_valid), 1);
        check("t2_head", int'(out_data), 8'h21);
        out_ready = 1'b1;
        repeat (40) tick();
        check("t2_reads", rden_cnt - base, 10);
        check("t2_rd_count_wrap", int'(rd_count), 0);
        check("t2_sb_empty", sb.size(), 0);

        // Single word: one read then EMPTY_WAIT, no second read
        base = rden_cnt;
        load(8'h33, 1, 1'b1);
        repeat (30) tick();
        check("t3_reads", rden_cnt - base, 1);
        check("t3_rd_count", int'(rd_count), 1);
        check("t3_sb_empty", sb.size(), 0);

        // Flush with one word buffered and three reads in flight (0x41..0x44 lost)
        out_ready = 1'b0;
        base = rden_cnt;
        load(8'h41, 10, 1'b0);
        for (int i = 4; i < 10; i++) sb.push_back(8'h41 + 8'(i));
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check("t4_valid_seen", int'(out_valid), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_valid_dropped", int'(out_valid), 0);
        check("t4_r_en_dropped", int'(r_en), 0);
        check("t4_busy_first", int'(flush_busy), 1);
        busy = 0;
        repeat (8) begin
            if (flush_busy) busy++;
            tick();
        end
        check("t4_busy_cycles", busy, 2);
        check("t4_rd_count_kept", int'(rd_count), 1);
        out_ready = 1'b1;
        repeat (40) tick();
        check("t4_reads", rden_cnt - base, 10);
        check("t4_rd_count", int'(rd_count), 7);
        check("t4_sb_empty", sb.size(), 0);

        // Reset mid-burst, then resume from the FIFO's current head
        base = hs_cnt;
        load(8'h51, 8, 1'b1);
        n = 0;
        while ((hs_cnt - base) < 3 && n < 40) begin
            tick();
            n++;
        end
        check("t5_progress", int'((hs_cnt - base) >= 3), 1);
        rrst_n = 1'b0;
        tick();
        check_reset_vals("t5");
        sb.delete();
        for (int i = head; i < tail; i++) sb.push_back(fmem[i]);
        rem = tail - head;
        rrst_n = 1'b1;
        repeat (40) tick();
        check("t5_rd_count", int'(rd_count), rem);
        check("t5_sb_empty", sb.size(), 0);

        // Disabled: no reads; then enough words to wrap the 4-bit counter to 1
        enable = 1'b0;
        base = rden_cnt;
        load(8'h61, 17 - rem, 1'b1);
        repeat (10) tick();
        check("t6_no_reads_disabled", rden_cnt - base, 0);
        check("t6_idle_valid", int'(out_valid), 0);
        enable = 1'b1;
        repeat (80) tick();
        check("t6_rd_count_wrap", int'(rd_count), 1);
        check("t6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
